// File: rtl/rpc2_ctrl_axi_wr_data_buf.sv
// rpc2_ctrl_axi_wr_data_buf
//   AXI write-data buffer for the RPC2 controller. Write-burst descriptors from
//   the AW path are queued. W beats are accepted against the active
//   descriptor, their strobes are masked to the legal narrow-transfer lanes,
//   and the beats are buffered in an internal FIFO. The FIFO presents them
//   first-word-fall-through to the IP side, with a per-burst last flag.
//
//   Optional feature: define RPC2_CTRL_WLAST_CHECK_EN to flag AXI_WLAST
//   mismatches in the sticky wlast_err output. When it is undefined, AXI_WLAST
//   is ignored and wlast_err is tied low.
//
//   Ports
//     clk, reset            clock, asynchronous active-high reset
//     AXI_W*                AXI write-data channel (AXI_WREADY registered)
//     wready_req/len/size/fixed/strb
//                           descriptor push from the AW path
//     wready_ack            descriptor accepted (combinational)
//     cmd_full              descriptor queue full
//     wready_done           one-cycle pulse after the last beat of a burst is accepted
//     ip_data_ready         IP consumes the head beat
//     axi2ip_data_valid/data/strb/last
//                           head beat of the buffer (zero when empty)
//     wlast_err             sticky WLAST mismatch flag
//     dat_count             number of beats buffered
module rpc2_ctrl_axi_wr_data_buf #(
    parameter int unsigned C_AXI_DATA_WIDTH = 32,
    parameter int unsigned CMD_DEPTH        = 4,
    parameter int unsigned DAT_DEPTH        = 16,
    parameter int unsigned LEN_WIDTH        = 8
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [C_AXI_DATA_WIDTH-1:0]     AXI_WDATA,
    input  logic [C_AXI_DATA_WIDTH/8-1:0]   AXI_WSTRB,
    input  logic                            AXI_WLAST,
    input  logic                            AXI_WVALID,
    output logic                            AXI_WREADY,
    input  logic                            wready_req,
    input  logic [LEN_WIDTH-1:0]            wready_len,
    input  logic [1:0]                      wready_size,
    input  logic                            wready_fixed,
    input  logic [C_AXI_DATA_WIDTH/8-1:0]   wready_strb,
    output logic                            wready_ack,
    output logic                            cmd_full,
    output logic                            wready_done,
    input  logic                            ip_data_ready,
    output logic                            axi2ip_data_valid,
    output logic [C_AXI_DATA_WIDTH-1:0]     axi2ip_data,
    output logic [C_AXI_DATA_WIDTH/8-1:0]   axi2ip_strb,
    output logic                            axi2ip_last,
    output logic                            wlast_err,
    output logic [$clog2(DAT_DEPTH):0]      dat_count
);

    localparam int unsigned STRB_W    = C_AXI_DATA_WIDTH / 8;
    localparam int unsigned CMD_AW    = $clog2(CMD_DEPTH);
    localparam int unsigned CMD_CNT_W = CMD_AW + 1;
    localparam int unsigned DAT_AW    = $clog2(DAT_DEPTH);
    localparam int unsigned CNT_W     = DAT_AW + 1;
    localparam int unsigned DESC_W    = LEN_WIDTH + 2 + 1 + STRB_W;
    localparam int unsigned BEAT_W    = 1 + STRB_W + C_AXI_DATA_WIDTH;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    state_t                 state, state_n;

    // Descriptor queue
    logic [DESC_W-1:0]      cmd_mem [CMD_DEPTH];
    logic [CMD_AW-1:0]      cmd_wr_ptr, cmd_rd_ptr;
    logic [CMD_CNT_W-1:0]   cmd_cnt;
    logic                   cmd_empty;
    logic                   cmd_push, cmd_pop;
    logic [DESC_W-1:0]      desc_in, desc_head;
    logic [LEN_WIDTH-1:0]   head_len;
    logic [1:0]             head_size;
    logic                   head_fixed;
    logic [STRB_W-1:0]      head_strb;

    // Active burst
    logic [LEN_WIDTH-1:0]   beat_cnt;
    logic [STRB_W-1:0]      lane_mask;
    logic [1:0]             size_q;
    logic                   fixed_q;
    logic                   wready_q, wready_n;
    logic                   done_q;
    logic                   beat_acc, beat_last;
    logic [4:0]             lane_bytes;
    logic                   rotate_en;
    logic [2*STRB_W-1:0]    rot_wide;
    logic [STRB_W-1:0]      lane_rot;

    // Beat FIFO
    logic [BEAT_W-1:0]      dat_mem [DAT_DEPTH];
    logic [DAT_AW-1:0]      dat_wr_ptr, dat_rd_ptr;
    logic [CNT_W-1:0]       dat_cnt, dat_cnt_n;
    logic                   dat_push, dat_pop, dat_valid;
    logic [BEAT_W-1:0]      beat_in, beat_head;

    // Descriptor queue control and field unpacking
    assign cmd_full   = (cmd_cnt == CMD_CNT_W'(CMD_DEPTH));
    assign cmd_empty  = (cmd_cnt == '0);
    assign wready_ack = wready_req & ~cmd_full;
    assign cmd_push   = wready_ack;
    assign desc_in    = {wready_len, wready_size, wready_fixed, wready_strb};
    assign desc_head  = cmd_mem[cmd_rd_ptr];
    assign head_len   = desc_head[DESC_W-1 -: LEN_WIDTH];
    assign head_size  = desc_head[STRB_W+2 -: 2];
    assign head_fixed = desc_head[STRB_W];
    assign head_strb  = desc_head[STRB_W-1:0];

    // Descriptor storage
    always_ff @(posedge clk) begin
        if (cmd_push) begin
            cmd_mem[cmd_wr_ptr] <= desc_in;
        end
    end

    // Descriptor pointers and occupancy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cmd_wr_ptr <= '0;
            cmd_rd_ptr <= '0;
            cmd_cnt    <= '0;
        end else begin
            if (cmd_push) cmd_wr_ptr <= cmd_wr_ptr + CMD_AW'(1);
            if (cmd_pop)  cmd_rd_ptr <= cmd_rd_ptr + CMD_AW'(1);
            case ({cmd_push, cmd_pop})
                2'b10:   cmd_cnt <= cmd_cnt + CMD_CNT_W'(1);
                2'b01:   cmd_cnt <= cmd_cnt - CMD_CNT_W'(1);
                default: cmd_cnt <= cmd_cnt;
            endcase
        end
    end

    // Beat handshake and lane rotation for narrow incrementing bursts
    assign beat_acc   = AXI_WVALID & wready_q;
    assign beat_last  = (beat_cnt == '0);
    assign lane_bytes = 5'd1 << size_q;
    assign rotate_en  = ~fixed_q && (32'(lane_bytes) < STRB_W);
    assign rot_wide   = {lane_mask, lane_mask} << lane_bytes;
    assign lane_rot   = rot_wide[2*STRB_W-1 -: STRB_W];

    // Beat FIFO control
    assign dat_push  = beat_acc;
    assign dat_valid = (dat_cnt != '0);
    assign dat_pop   = ip_data_ready & dat_valid;
    assign beat_in   = {beat_last, AXI_WSTRB & lane_mask, AXI_WDATA};
    assign beat_head = dat_mem[dat_rd_ptr];

    // FSM next state, descriptor pop, FIFO occupancy and next WREADY
    always_comb begin
        state_n   = state;
        cmd_pop   = 1'b0;
        dat_cnt_n = dat_cnt;
        wready_n  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!cmd_empty) begin
                    cmd_pop = 1'b1;
                    state_n = ST_BURST;
                end
            end
            ST_BURST: begin
                if (beat_acc && beat_last) begin
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
        case ({dat_push, dat_pop})
            2'b10:   dat_cnt_n = dat_cnt + CNT_W'(1);
            2'b01:   dat_cnt_n = dat_cnt - CNT_W'(1);
            default: dat_cnt_n = dat_cnt;
        endcase
        // WREADY rises one cycle after the pop that starts a burst and falls
        // on the edge that fills the FIFO or accepts the final beat.
        wready_n = (state == ST_BURST) && (state_n == ST_BURST) &&
                   (dat_cnt_n != CNT_W'(DAT_DEPTH));
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Active burst context, WREADY and done pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            beat_cnt  <= '0;
            lane_mask <= '0;
            size_q    <= '0;
            fixed_q   <= 1'b0;
            wready_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            wready_q <= wready_n;
            done_q   <= beat_acc & beat_last;
            if (cmd_pop) begin
                beat_cnt  <= head_len;
                lane_mask <= head_strb;
                size_q    <= head_size;
                fixed_q   <= head_fixed;
            end else if (beat_acc) begin
                if (!beat_last) beat_cnt <= beat_cnt - LEN_WIDTH'(1);
                if (rotate_en)  lane_mask <= lane_rot;
            end
        end
    end

    // Beat storage
    always_ff @(posedge clk) begin
        if (dat_push) begin
            dat_mem[dat_wr_ptr] <= beat_in;
        end
    end

    // Beat FIFO pointers and occupancy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dat_wr_ptr <= '0;
            dat_rd_ptr <= '0;
            dat_cnt    <= '0;
        end else begin
            if (dat_push) dat_wr_ptr <= dat_wr_ptr + DAT_AW'(1);
            if (dat_pop)  dat_rd_ptr <= dat_rd_ptr + DAT_AW'(1);
            dat_cnt <= dat_cnt_n;
        end
    end

`ifdef RPC2_CTRL_WLAST_CHECK_EN
    logic wlast_err_q;

    // Sticky mismatch between AXI_WLAST and the burst counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wlast_err_q <= 1'b0;
        end else if (beat_acc && (AXI_WLAST != beat_last)) begin
            wlast_err_q <= 1'b1;
        end
    end

    assign wlast_err = wlast_err_q;
`else
    logic wlast_unused;

    assign wlast_unused = AXI_WLAST;
    assign wlast_err    = 1'b0;
`endif

    // Output mapping; head fields read as zero while the FIFO is empty
    assign AXI_WREADY        = wready_q;
    assign wready_done       = done_q;
    assign axi2ip_data_valid = dat_valid;
    assign axi2ip_data       = dat_valid ? beat_head[C_AXI_DATA_WIDTH-1:0] : '0;
    assign axi2ip_strb       = dat_valid ? beat_head[C_AXI_DATA_WIDTH +: STRB_W] : '0;
    assign axi2ip_last       = dat_valid & beat_head[BEAT_W-1];
    assign dat_count         = dat_cnt;

endmodule

// File: tb/tb_rpc2_ctrl_axi_wr_data_buf.sv
// Directed testbench for rpc2_ctrl_axi_wr_data_buf (32-bit, CMD_DEPTH=4, DAT_DEPTH=16).
module tb_rpc2_ctrl_axi_wr_data_buf;

    logic        clk;
    logic        reset;
    logic [31:0] AXI_WDATA;
    logic [3:0]  AXI_WSTRB;
    logic        AXI_WLAST;
    logic        AXI_WVALID;
    logic        AXI_WREADY;
    logic        wready_req;
    logic [7:0]  wready_len;
    logic [1:0]  wready_size;
    logic        wready_fixed;
    logic [3:0]  wready_strb;
    logic        wready_ack;
    logic        cmd_full;
    logic        wready_done;
    logic        ip_data_ready;
    logic        axi2ip_data_valid;
    logic [31:0] axi2ip_data;
    logic [3:0]  axi2ip_strb;
    logic        axi2ip_last;
    logic        wlast_err;
    logic [4:0]  dat_count;

    int n_checks = 0;
    int n_errors = 0;

    logic [36:0] out_q[$];
    int          done_seen = 0;

    rpc2_ctrl_axi_wr_data_buf #(
        .C_AXI_DATA_WIDTH(32),
        .CMD_DEPTH       (4),
        .DAT_DEPTH       (16),
        .LEN_WIDTH       (8)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .AXI_WDATA        (AXI_WDATA),
        .AXI_WSTRB        (AXI_WSTRB),
        .AXI_WLAST        (AXI_WLAST),
        .AXI_WVALID       (AXI_WVALID),
        .AXI_WREADY       (AXI_WREADY),
        .wready_req       (wready_req),
        .wready_len       (wready_len),
        .wready_size      (wready_size),
        .wready_fixed     (wready_fixed),
        .wready_strb      (wready_strb),
        .wready_ack       (wready_ack),
        .cmd_full         (cmd_full),
        .wready_done      (wready_done),
        .ip_data_ready    (ip_data_ready),
        .axi2ip_data_valid(axi2ip_data_valid),
        .axi2ip_data      (axi2ip_data),
        .axi2ip_strb      (axi2ip_strb),
        .axi2ip_last      (axi2ip_last),
        .wlast_err        (wlast_err),
        .dat_count        (dat_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change just after posedge, so negedge sees the pre-edge values
    always @(negedge clk) begin
        if (!reset) begin
            if (axi2ip_data_valid && ip_data_ready)
                out_q.push_back({axi2ip_last, axi2ip_strb, axi2ip_data});
            if (wready_done)
                done_seen++;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves wready_req high so pushes can be issued back to back
    task automatic push_desc(input logic [7:0] len, input logic [1:0] size,
                             input logic fixed, input logic [3:0] strb,
                             output logic ack);
        wready_req   = 1'b1;
        wready_len   = len;
        wready_size  = size;
        wready_fixed = fixed;
        wready_strb  = strb;
        #1;
        ack = wready_ack;
        step();
    endtask

    task automatic send_beats(input string tag, input int n, input int data_base,
                              input logic [31:0] wlast_bits);
        logic acc;
        int   cyc;
        for (int i = 0; i < n; i++) begin
            AXI_WDATA  = 32'(data_base + i);
            AXI_WSTRB  = 4'hF;
            AXI_WLAST  = wlast_bits[i];
            AXI_WVALID = 1'b1;
            acc = 1'b0;
            cyc = 0;
            while (!acc && cyc < 200) begin
                @(negedge clk);
                acc = AXI_WREADY;
                step();
                cyc++;
            end
            check($sformatf("%s_accept%0d", tag, i), 64'(acc), 64'd1);
        end
        AXI_WVALID = 1'b0;
        AXI_WLAST  = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 200 && dat_count != 5'd0; i++) step();
        step();
        step();
        check($sformatf("%s_drained", tag), 64'(dat_count), 64'd0);
    endtask

    // Beat i: strobe nibble strbs[4i+:4], last flag last_bits[i], data data_base+i
    task automatic check_beats(input string tag, input int base, input int n,
                               input int data_base, input logic [79:0] strbs,
                               input logic [31:0] last_bits);
        logic [36:0] e;
        check($sformatf("%s_count", tag), 64'(out_q.size() - base), 64'(n));
        for (int i = 0; i < n; i++) begin
            e = (base + i < out_q.size()) ? out_q[base + i] : 37'h0;
            check($sformatf("%s_data%0d", tag, i), 64'(e[31:0]), 64'(32'(data_base + i)));
            check($sformatf("%s_strb%0d", tag, i), 64'(e[35:32]), 64'(strbs[i*4 +: 4]));
            check($sformatf("%s_last%0d", tag, i), 64'(e[36]), 64'(last_bits[i]));
        end
    endtask

    initial begin
        logic       ack;
        logic [4:0] acks;
        int         base;
        int         dbase;
        int         cyc;

        reset         = 1'b1;
        AXI_WDATA     = '0;
        AXI_WSTRB     = '0;
        AXI_WLAST     = 1'b0;
        AXI_WVALID    = 1'b0;
        wready_req    = 1'b0;
        wready_len    = '0;
        wready_size   = '0;
        wready_fixed  = 1'b0;
        wready_strb   = '0;
        ip_data_ready = 1'b0;
        step();
        step();

        // Reset values
        check("rst_wready",  64'(AXI_WREADY), 64'd0);
        check("rst_done",    64'(wready_done), 64'd0);
        check("rst_valid",   64'(axi2ip_data_valid), 64'd0);
        check("rst_last",    64'(axi2ip_last), 64'd0);
        check("rst_wlasterr", 64'(wlast_err), 64'd0);
        check("rst_cmdfull", 64'(cmd_full), 64'd0);
        check("rst_count",   64'(dat_count), 64'd0);
        check("rst_data",    64'(axi2ip_data), 64'd0);
        check("rst_strb",    64'(axi2ip_strb), 64'd0);
        reset = 1'b0;
        step();

        // Full-width incrementing burst of 4 beats
        ip_data_ready = 1'b1;
        base  = out_q.size();
        dbase = done_seen;
        push_desc(8'd3, 2'd2, 1'b0, 4'hF, ack);
        wready_req = 1'b0;
        check("t1_ack", 64'(ack), 64'd1);
        check("t1_wready_n0", 64'(AXI_WREADY), 64'd0);
        step();
        check("t1_wready_n1", 64'(AXI_WREADY), 64'd0);
        step();
        check("t1_wready_n2", 64'(AXI_WREADY), 64'd1);
        send_beats("t1", 4, 32'h100, 32'h8);
        drain("t1");
        check_beats("t1", base, 4, 32'h100, 80'hFFFF, 32'h8);
        check("t1_done", 64'(done_seen - dbase), 64'd1);

        // Narrow byte-wide incrementing burst rotates lanes from lane 2
        base = out_q.size();
        push_desc(8'd3, 2'd0, 1'b0, 4'h4, ack);
        wready_req = 1'b0;
        send_beats("t2", 4, 32'h200, 32'h8);
        drain("t2");
        check_beats("t2", base, 4, 32'h200, 80'h2184, 32'h8);

        // Same burst as FIXED keeps lane 2
        base = out_q.size();
        push_desc(8'd3, 2'd0, 1'b1, 4'h4, ack);
        wready_req = 1'b0;
        send_beats("t2f", 4, 32'h210, 32'h8);
        drain("t2f");
        check_beats("t2f", base, 4, 32'h210, 80'h4444, 32'h8);

        // Descriptor queue full: hold the FSM in a burst, then push five
        base  = out_q.size();
        dbase = done_seen;
        push_desc(8'd0, 2'd2, 1'b0, 4'hF, ack);
        wready_req = 1'b0;
        cyc = 0;
        while (!AXI_WREADY && cyc < 20) begin
            step();
            cyc++;
        end
        check("t3_hold_wready", 64'(AXI_WREADY), 64'd1);
        push_desc(8'd0, 2'd2, 1'b0, 4'h1, ack); acks[0] = ack;
        push_desc(8'd1, 2'd2, 1'b0, 4'h3, ack); acks[1] = ack;
        push_desc(8'd2, 2'd2, 1'b0, 4'h7, ack); acks[2] = ack;
        push_desc(8'd3, 2'd2, 1'b0, 4'hC, ack); acks[3] = ack;
        push_desc(8'd4, 2'd2, 1'b0, 4'hF, ack); acks[4] = ack;
        wready_req = 1'b0;
        check("t3_acks", 64'(acks), 64'h0F);
        check("t3_cmdfull", 64'(cmd_full), 64'd1);
        send_beats("t3", 11, 32'h300, 32'h44B);
        drain("t3");
        check_beats("t3", base, 11, 32'h300, 80'hCCCC777331F, 32'h44B);
        check("t3_done", 64'(done_seen - dbase), 64'd5);
        check("t3_cmdfull_after", 64'(cmd_full), 64'd0);
        check("t3_no_fifth", 64'(AXI_WREADY), 64'd0);

        // Backpressure: 20-beat burst into a 16-deep buffer
        ip_data_ready = 1'b0;
        base = out_q.size();
        push_desc(8'd19, 2'd2, 1'b0, 4'hF, ack);
        wready_req = 1'b0;
        send_beats("t4a", 16, 32'h400, 32'h0);
        check("t4_wready_full", 64'(AXI_WREADY), 64'd0);
        AXI_WDATA  = 32'h410;
        AXI_WVALID = 1'b1;
        step();
        step();
        step();
        check("t4_wready_held", 64'(AXI_WREADY), 64'd0);
        check("t4_count_full", 64'(dat_count), 64'd16);
        ip_data_ready = 1'b1;
        send_beats("t4b", 4, 32'h410, 32'h8);
        drain("t4");
        check_beats("t4", base, 20, 32'h400, {20{4'hF}}, 32'h80000);
        check("t4_wlasterr", 64'(wlast_err), 64'd0);

        // Early WLAST on beat 2; burst still ends on the counter
        base  = out_q.size();
        dbase = done_seen;
        push_desc(8'd3, 2'd2, 1'b0, 4'hF, ack);
        wready_req = 1'b0;
        send_beats("t5", 4, 32'h500, 32'hA);
        drain("t5");
        check_beats("t5", base, 4, 32'h500, 80'hFFFF, 32'h8);
        check("t5_done", 64'(done_seen - dbase), 64'd1);
`ifdef RPC2_CTRL_WLAST_CHECK_EN
        check("t5_wlasterr", 64'(wlast_err), 64'd1);
`else
        check("t5_wlasterr", 64'(wlast_err), 64'd0);
`endif

        // Reset mid-burst with beats buffered and a descriptor still queued
        ip_data_ready = 1'b0;
        push_desc(8'd3, 2'd2, 1'b0, 4'hF, ack);
        push_desc(8'd0, 2'd2, 1'b0, 4'hF, ack);
        wready_req = 1'b0;
        send_beats("t6a", 2, 32'h600, 32'h0);
        check("t6_count_pre", 64'(dat_count), 64'd2);
        reset = 1'b1;
        #1;
        check("t6_rst_wready",  64'(AXI_WREADY), 64'd0);
        check("t6_rst_valid",   64'(axi2ip_data_valid), 64'd0);
        check("t6_rst_count",   64'(dat_count), 64'd0);
        check("t6_rst_cmdfull", 64'(cmd_full), 64'd0);
        check("t6_rst_data",    64'(axi2ip_data), 64'd0);
        check("t6_rst_last",    64'(axi2ip_last), 64'd0);
        check("t6_rst_wlasterr", 64'(wlast_err), 64'd0);
        step();
        reset = 1'b0;
        step();
        step();
        step();
        step();
        check("t6_queue_empty", 64'(AXI_WREADY), 64'd0);
        ip_data_ready = 1'b1;
        base  = out_q.size();
        dbase = done_seen;
        push_desc(8'd0, 2'd2, 1'b0, 4'hF, ack);
        wready_req = 1'b0;
        send_beats("t6b", 1, 32'h700, 32'h1);
        drain("t6");
        check_beats("t6", base, 1, 32'h700, 80'hF, 32'h1);
        check("t6_done", 64'(done_seen - dbase), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
